stall_ctrl: RTL and testbench

//  Central pipeline stall sequencer. Collects stall requests from IF (inst SRAM wait),
//  ID (load-use hazard) and EX (multi-cycle ops such as div/mult), and sequences them.

---
 rtl/stall_ctrl_pkg.sv | 40 ++++
 rtl/stall_cnt.sv | 38 +++
 rtl/stall_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stall_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: stall-bus width,
// the per-cause stall encodings, FSM state type and the winning-cause type.
package stall_ctrl_pkg;

   localparam int STALL_W = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // bit0 = PC ... bit5 = MEM/WB register; a 1 freezes that stage
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } mcState_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_IF   = 2'd1,
      CAUSE_ID   = 2'd2,
      CAUSE_EX   = 2'd3
   } cause_e;

   // Maps the winning stall cause onto the stall-bus pattern
   function automatic logic [STALL_W-1:0] stallEncode(input cause_e cause);
      logic [STALL_W-1:0] vec;
      case (cause)
         CAUSE_EX: vec = STALL_EX;
         CAUSE_ID: vec = STALL_ID;
         CAUSE_IF: vec = STALL_IF;
         default:  vec = STALL_NONE;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/stall_cnt.sv
// Wrapping per-cause stall statistics counter with synchronous clear.
module stall_cnt
   import stall_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear beats increment; the counter rolls over from all-ones to zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Central pipeline stall sequencer: arbitrates IF/ID/EX stall requests
// (deepest stage wins), sequences EX multi-cycle ops with a countdown FSM,
// keeps per-cause stall statistics and raises sticky protocol-error flags.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int MC_W     = 6,
   parameter int CNT_W    = 32,
   parameter int HANG_MAX = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_if,
   input  logic               stallreq_id,
   input  logic               ex_mc_start,
   input  logic [MC_W-1:0]    ex_mc_cycles,
   input  logic               perf_clr,
   output logic [STALL_W-1:0] stall,
   output logic               ex_mc_busy,
   output logic               ex_mc_done,
   output logic               mc_overlap_err,
   output logic               id_hang_err,
   output logic [CNT_W-1:0]   cnt_stall_ex,
   output logic [CNT_W-1:0]   cnt_stall_id,
   output logic [CNT_W-1:0]   cnt_stall_if
);

   localparam int RUN_W = $clog2(HANG_MAX + 1);
   localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(HANG_MAX);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HANG_MAX - 1);

   mcState_e          state_q;
   mcState_e          state_d;
   logic [MC_W-1:0]   remaining_q;
   logic [MC_W-1:0]   remaining_d;
   logic [RUN_W-1:0]  runLen_q;
   logic [RUN_W-1:0]  runLen_d;
   logic              idHangErr_q;
   logic              idHangErr_d;
   logic              mcOverlapErr_q;
   logic              mcOverlapErr_d;
   logic [MC_W-1:0]   mcLen;
   logic              mcDone;
   cause_e            cause;

   // A zero-length request still costs one stall cycle
   assign mcLen = (ex_mc_cycles == '0) ? MC_W'(1) : ex_mc_cycles;

   // Countdown FSM: the start cycle is the first stalled cycle, so BUSY lasts N-1 cycles
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      mcDone      = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_mc_start) begin
               if (mcLen == MC_W'(1)) begin
                  mcDone = 1'b1;
               end else begin
                  state_d     = MC_BUSY;
                  remaining_d = mcLen - MC_W'(1);
               end
            end
         end
         MC_BUSY: begin
            remaining_d = remaining_q - MC_W'(1);
            if (remaining_q == MC_W'(1)) begin
               mcDone  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // FSM state and countdown registers; reset aborts any op in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   // Priority arbitration: EX over ID over IF, exactly one cause wins
   always_comb begin
      cause = CAUSE_NONE;
      if ((state_q == MC_BUSY) || ex_mc_start) begin
         cause = CAUSE_EX;
      end else if (stallreq_id) begin
         cause = CAUSE_ID;
      end else if (stallreq_if) begin
         cause = CAUSE_IF;
      end
   end

   // Watchdog run length and sticky error flags; perf_clr wipes all of them
   always_comb begin
      runLen_d       = runLen_q;
      idHangErr_d    = idHangErr_q;
      mcOverlapErr_d = mcOverlapErr_q;
      if (perf_clr) begin
         runLen_d       = '0;
         idHangErr_d    = 1'b0;
         mcOverlapErr_d = 1'b0;
      end else begin
         if (cause == CAUSE_ID) begin
            if (runLen_q != RUN_SAT) begin
               runLen_d = runLen_q + 1'b1;
            end
            if (runLen_q == RUN_LAST) begin
               idHangErr_d = 1'b1;
            end
         end else begin
            runLen_d = '0;
         end
         if (ex_mc_start && (state_q == MC_BUSY)) begin
            mcOverlapErr_d = 1'b1;
         end
      end
   end

   // Watchdog and error flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runLen_q       <= '0;
         idHangErr_q    <= 1'b0;
         mcOverlapErr_q <= 1'b0;
      end else begin
         runLen_q       <= runLen_d;
         idHangErr_q    <= idHangErr_d;
         mcOverlapErr_q <= mcOverlapErr_d;
      end
   end

   stall_cnt #(.CNT_W(CNT_W)) uCntEx (
      .clk   (clk),
      .rst   (rst),
      .inc_i ((cause == CAUSE_EX) && !perf_clr),
      .clr_i (perf_clr),
      .cnt_o (cnt_stall_ex)
   );

   stall_cnt #(.CNT_W(CNT_W)) uCntId (
      .clk   (clk),
      .rst   (rst),
      .inc_i ((cause == CAUSE_ID) && !perf_clr),
      .clr_i (perf_clr),
      .cnt_o (cnt_stall_id)
   );

   stall_cnt #(.CNT_W(CNT_W)) uCntIf (
      .clk   (clk),
      .rst   (rst),
      .inc_i ((cause == CAUSE_IF) && !perf_clr),
      .clr_i (perf_clr),
      .cnt_o (cnt_stall_if)
   );

   // Reset forces the bus quiet at once, even with requests still asserted
   assign stall          = rst ? STALL_NONE : stallEncode(cause);
   assign ex_mc_done     = mcDone && !rst;
   assign ex_mc_busy     = (state_q == MC_BUSY);
   assign mc_overlap_err = mcOverlapErr_q;
   assign id_hang_err    = idHangErr_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl. Inputs change on the falling
// edge; outputs are sampled 2 time units later, well clear of the rising edge.
module tb_stall_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreqIf;
   logic        stallreqId;
   logic        exMcStart;
   logic [5:0]  exMcCycles;
   logic        perfClr;
   logic [5:0]  stall;
   logic        exMcBusy;
   logic        exMcDone;
   logic        mcOverlapErr;
   logic        idHangErr;
   logic [31:0] cntEx;
   logic [31:0] cntId;
   logic [31:0] cntIf;

   int checks;
   int failures;

   stall_ctrl #(.MC_W(6), .CNT_W(32), .HANG_MAX(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_if    (stallreqIf),
      .stallreq_id    (stallreqId),
      .ex_mc_start    (exMcStart),
      .ex_mc_cycles   (exMcCycles),
      .perf_clr       (perfClr),
      .stall          (stall),
      .ex_mc_busy     (exMcBusy),
      .ex_mc_done     (exMcDone),
      .mc_overlap_err (mcOverlapErr),
      .id_hang_err    (idHangErr),
      .cnt_stall_ex   (cntEx),
      .cnt_stall_id   (cntId),
      .cnt_stall_if   (cntIf)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Pulse perf_clr for one edge to zero counters and flags
   task applyStimulus_clear;
      @(negedge clk);
      perfClr = 1'b1;
      @(negedge clk);
      perfClr = 1'b0;
   endtask

   task test_reset;
      rst = 1'b1; stallreqIf = 1'b1; stallreqId = 1'b1;
      exMcStart = 1'b1; exMcCycles = 6'd5; perfClr = 1'b0;
      @(negedge clk); #2;
      checks++;
      if (stall !== 6'b000000) begin
         failures++; $display("[TB] FAIL reset_stall: got %b expected %b", stall, 6'b000000);
      end
      checks++;
      if (exMcBusy !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_busy: got %b expected 0", exMcBusy);
      end
      @(negedge clk);
      rst = 1'b0; stallreqIf = 1'b0; stallreqId = 1'b0; exMcStart = 1'b0;
      #2;
      checks++;
      if (stall !== 6'b000000) begin
         failures++; $display("[TB] FAIL idle_stall: got %b expected %b", stall, 6'b000000);
      end
      @(negedge clk); #2;
      checks++;
      if ({cntEx, cntId, cntIf} !== 96'd0) begin
         failures++; $display("[TB] FAIL reset_counters: got ex=%0d id=%0d if=%0d expected 0", cntEx, cntId, cntIf);
      end
      checks++;
      if ({mcOverlapErr, idHangErr, exMcBusy} !== 3'b000) begin
         failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {mcOverlapErr, idHangErr, exMcBusy});
      end
   endtask

   task test_id_stall;
      applyStimulus_clear();
      stallreqId = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         #2;
         checks++;
         if (stall !== 6'b000111) begin
            failures++; $display("[TB] FAIL id_stall_c%0d: got %b expected %b", c, stall, 6'b000111);
         end
         @(negedge clk);
      end
      stallreqId = 1'b0;
      #2;
      checks++;
      if (cntId !== 32'd3) begin
         failures++; $display("[TB] FAIL id_count: got %0d expected 3", cntId);
      end
      checks++;
      if (stall !== 6'b000000) begin
         failures++; $display("[TB] FAIL id_release: got %b expected 0", stall);
      end
   endtask

   task test_if_stall;
      applyStimulus_clear();
      stallreqIf = 1'b1;
      #2;
      checks++;
      if (stall !== 6'b000011) begin
         failures++; $display("[TB] FAIL if_stall: got %b expected %b", stall, 6'b000011);
      end
      @(negedge clk);
      stallreqIf = 1'b0;
      #2;
      checks++;
      if ({cntIf, cntId, cntEx} !== {32'd1, 32'd0, 32'd0}) begin
         failures++; $display("[TB] FAIL if_count: got if=%0d id=%0d ex=%0d expected 1/0/0", cntIf, cntId, cntEx);
      end
   endtask

   task test_multicycle;
      applyStimulus_clear();
      exMcStart = 1'b1; exMcCycles = 6'd5;
      for (int c = 1; c <= 5; c++) begin
         #2;
         checks++;
         if ({stall, exMcDone, exMcBusy} !== {6'b001111, (c == 5), (c >= 2)}) begin
            failures++;
            $display("[TB] FAIL mc5_c%0d: got stall=%b done=%b busy=%b expected stall=001111 done=%b busy=%b",
                     c, stall, exMcDone, exMcBusy, (c == 5), (c >= 2));
         end
         @(negedge clk);
         exMcStart = 1'b0;
      end
      #2;
      checks++;
      if ({stall, exMcBusy, exMcDone} !== {6'b000000, 1'b0, 1'b0}) begin
         failures++; $display("[TB] FAIL mc5_end: got stall=%b busy=%b done=%b expected 0", stall, exMcBusy, exMcDone);
      end
      checks++;
      if (cntEx !== 32'd5) begin
         failures++; $display("[TB] FAIL mc5_count: got %0d expected 5", cntEx);
      end
      // Zero length behaves as a single stall cycle
      @(negedge clk);
      exMcStart = 1'b1; exMcCycles = 6'd0;
      #2;
      checks++;
      if ({stall, exMcDone, exMcBusy} !== {6'b001111, 1'b1, 1'b0}) begin
         failures++; $display("[TB] FAIL mc0: got stall=%b done=%b busy=%b expected 001111 1 0", stall, exMcDone, exMcBusy);
      end
      @(negedge clk);
      exMcStart = 1'b0;
      #2;
      checks++;
      if ({stall, exMcBusy, cntEx} !== {6'b000000, 1'b0, 32'd6}) begin
         failures++; $display("[TB] FAIL mc0_after: got stall=%b busy=%b cnt=%0d expected 0 0 6", stall, exMcBusy, cntEx);
      end
   endtask

   task test_priority;
      applyStimulus_clear();
      stallreqIf = 1'b1; stallreqId = 1'b1; exMcStart = 1'b1; exMcCycles = 6'd2;
      #2;
      checks++;
      if ({stall, exMcDone} !== {6'b001111, 1'b0}) begin
         failures++; $display("[TB] FAIL prio_c1: got stall=%b done=%b expected 001111 0", stall, exMcDone);
      end
      @(negedge clk);
      exMcStart = 1'b0;
      #2;
      checks++;
      if ({stall, exMcDone} !== {6'b001111, 1'b1}) begin
         failures++; $display("[TB] FAIL prio_c2: got stall=%b done=%b expected 001111 1", stall, exMcDone);
      end
      @(negedge clk); #2;
      checks++;
      if (stall !== 6'b000111) begin
         failures++; $display("[TB] FAIL prio_c3: got %b expected %b", stall, 6'b000111);
      end
      checks++;
      if ({cntEx, cntId, cntIf} !== {32'd2, 32'd0, 32'd0}) begin
         failures++; $display("[TB] FAIL prio_counts: got ex=%0d id=%0d if=%0d expected 2/0/0", cntEx, cntId, cntIf);
      end
      @(negedge clk);
      stallreqIf = 1'b0; stallreqId = 1'b0;
      #2;
      checks++;
      if ({cntEx, cntId, cntIf} !== {32'd2, 32'd1, 32'd0}) begin
         failures++; $display("[TB] FAIL prio_counts2: got ex=%0d id=%0d if=%0d expected 2/1/0", cntEx, cntId, cntIf);
      end
   endtask

   task test_overlap;
      applyStimulus_clear();
      exMcStart = 1'b1; exMcCycles = 6'd4;
      @(negedge clk);
      exMcCycles = 6'd7;
      #2;
      checks++;
      if ({stall, exMcBusy} !== {6'b001111, 1'b1}) begin
         failures++; $display("[TB] FAIL ovl_c2: got stall=%b busy=%b expected 001111 1", stall, exMcBusy);
      end
      @(negedge clk);
      exMcStart = 1'b0;
      #2;
      checks++;
      if (mcOverlapErr !== 1'b1) begin
         failures++; $display("[TB] FAIL ovl_flag: got %b expected 1", mcOverlapErr);
      end
      @(negedge clk); #2;
      checks++;
      if ({stall, exMcDone} !== {6'b001111, 1'b1}) begin
         failures++; $display("[TB] FAIL ovl_c4: got stall=%b done=%b expected 001111 1", stall, exMcDone);
      end
      @(negedge clk); #2;
      checks++;
      if ({stall, exMcBusy, cntEx, mcOverlapErr} !== {6'b000000, 1'b0, 32'd4, 1'b1}) begin
         failures++;
         $display("[TB] FAIL ovl_end: got stall=%b busy=%b cnt=%0d err=%b expected 0 0 4 1", stall, exMcBusy, cntEx, mcOverlapErr);
      end
      // perf_clr with an ID request in the same cycle: cleared, not counted
      @(negedge clk);
      perfClr = 1'b1; stallreqId = 1'b1;
      @(negedge clk);
      perfClr = 1'b0; stallreqId = 1'b0;
      #2;
      checks++;
      if ({mcOverlapErr, cntEx, cntId} !== {1'b0, 32'd0, 32'd0}) begin
         failures++; $display("[TB] FAIL perf_clr: got err=%b ex=%0d id=%0d expected 0 0 0", mcOverlapErr, cntEx, cntId);
      end
   endtask

   task test_hang;
      applyStimulus_clear();
      // An interrupted run must not trip the watchdog
      stallreqId = 1'b1;
      repeat (40) @(negedge clk);
      stallreqId = 1'b0;
      @(negedge clk);
      stallreqId = 1'b1;
      repeat (40) @(negedge clk);
      stallreqId = 1'b0;
      #2;
      checks++;
      if (idHangErr !== 1'b0) begin
         failures++; $display("[TB] FAIL hang_split: got %b expected 0", idHangErr);
      end
      @(negedge clk);
      stallreqId = 1'b1;
      repeat (63) @(negedge clk);
      #2;
      checks++;
      if (idHangErr !== 1'b0) begin
         failures++; $display("[TB] FAIL hang_63: got %b expected 0", idHangErr);
      end
      checks++;
      if (stall !== 6'b000111) begin
         failures++; $display("[TB] FAIL hang_stall: got %b expected %b", stall, 6'b000111);
      end
      @(negedge clk);
      stallreqId = 1'b0;
      #2;
      checks++;
      if ({idHangErr, cntId} !== {1'b1, 32'd144}) begin
         failures++; $display("[TB] FAIL hang_64: got err=%b id=%0d expected 1 144", idHangErr, cntId);
      end
      @(negedge clk); #2;
      checks++;
      if (idHangErr !== 1'b1) begin
         failures++; $display("[TB] FAIL hang_sticky: got %b expected 1", idHangErr);
      end
   endtask

   task test_reset_mid_busy;
      @(negedge clk);
      exMcStart = 1'b1; exMcCycles = 6'd10;
      @(negedge clk);
      exMcStart = 1'b0;
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({stall, exMcBusy, idHangErr} !== {6'b000000, 1'b0, 1'b0}) begin
         failures++; $display("[TB] FAIL rst_mid: got stall=%b busy=%b hang=%b expected 0 0 0", stall, exMcBusy, idHangErr);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #2;
      checks++;
      if ({stall, exMcBusy, cntEx} !== {6'b000000, 1'b0, 32'd0}) begin
         failures++; $display("[TB] FAIL rst_resume: got stall=%b busy=%b ex=%0d expected 0 0 0", stall, exMcBusy, cntEx);
      end
   endtask

   // Run every scenario in order and report the tally
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_id_stall();
      test_if_stall();
      test_multicycle();
      test_priority();
      test_overlap();
      test_hang();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
